fft_sequencer: RTL and testbench

Control block that streams real IEEE-754 single-precision samples into the combinational 8-point FFT datapath (`mainCalc`), waits a fixed settle window, captures its four 64-bit complex results and streams them out. It sits between the sample source and the result consumer. It owns the 256-bit frame register feeding `mainCalc` and the result holding registers.

---
 rtl/fft_pkg.sv | 16 +
 rtl/fft_frame_buffer.sv | 31 +++
 rtl/fft_sequencer.sv | 102 ++++++++++
 tb/tb_fft_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants and the sequencer state type for the 8-point FFT blocks.
package fft_pkg;

  localparam int FFT_N    = 8;
  localparam int SAMPLE_W = 32;
  localparam int CPLX_W   = 64;
  localparam int FRAME_W  = 256;
  localparam int IDX_W    = $clog2(FFT_N);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    DRAIN  = 2'd2
  } fft_seq_state_t;

endpackage

// File: rtl/fft_frame_buffer.sv
// 8 x 32-bit slot-addressed frame register with a flat 256-bit read.
// Slot 0 lands in the MSBs of frame_o.
module fft_frame_buffer
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_addr_i,
  input  logic [SAMPLE_W-1:0] wr_data_i,
  output logic [FRAME_W-1:0]  frame_o
);

  logic [SAMPLE_W-1:0] slot_q [FFT_N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FFT_N; i++) slot_q[i] <= '0;
    end else if (wr_en_i) begin
      slot_q[wr_addr_i] <= wr_data_i;
    end
  end

  always_comb begin
    frame_o = '0;
    for (int i = 0; i < FFT_N; i++) begin
      frame_o[FRAME_W-1-SAMPLE_W*i -: SAMPLE_W] = slot_q[i];
    end
  end

endmodule

// File: rtl/fft_sequencer.sv
// Loads 8 real samples into the mainCalc frame, waits SETTLE_CYCLES, captures
// the four complex results and streams them out in index order.
module fft_sequencer
  import fft_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [FRAME_W-1:0]  fft_frame,
  input  logic [CPLX_W-1:0]   fft_out1,
  input  logic [CPLX_W-1:0]   fft_out2,
  input  logic [CPLX_W-1:0]   fft_out3,
  input  logic [CPLX_W-1:0]   fft_out4,
  output logic [CPLX_W-1:0]   out_data,
  output logic [1:0]          out_index,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
    $error("fft_sequencer: SETTLE_CYCLES must be in 1..255");
  end

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_ready/out_valid depend on state_q only, so no input reaches them.
  fft_seq_state_t    state_q;
  logic [IDX_W-1:0]  wr_cnt_q;
  logic [7:0]        settle_cnt_q;
  logic [1:0]        rd_idx_q;
  logic [CPLX_W-1:0] res_q [4];
  logic [CPLX_W-1:0] out_data_q;
  logic              accept;

  assign accept    = in_valid && (state_q == LOAD);
  assign in_ready  = (state_q == LOAD);
  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == SETTLE) || (state_q == DRAIN);
  assign out_data  = out_data_q;
  assign out_index = rd_idx_q;

  fft_frame_buffer u_frame (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (accept),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (in_data),
    .frame_o   (fft_frame)
  );

  // out_data_q always mirrors res_q[rd_idx_q] so out_data is a pure register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= LOAD;
      wr_cnt_q     <= '0;
      settle_cnt_q <= '0;
      rd_idx_q     <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < 4; i++) res_q[i] <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          if (accept) begin
            wr_cnt_q <= wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd7) begin
              state_q      <= SETTLE;
              settle_cnt_q <= SETTLE_LOAD;
            end
          end
        end
        SETTLE: begin
          if (settle_cnt_q == 8'd0) begin
            res_q[0]   <= fft_out1;
            res_q[1]   <= fft_out2;
            res_q[2]   <= fft_out3;
            res_q[3]   <= fft_out4;
            out_data_q <= fft_out1;
            rd_idx_q   <= 2'd0;
            state_q    <= DRAIN;
          end else begin
            settle_cnt_q <= settle_cnt_q - 8'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            rd_idx_q   <= rd_idx_q + 2'd1;
            out_data_q <= res_q[rd_idx_q + 2'd1];
            if (rd_idx_q == 2'd3) state_q <= LOAD;
          end
        end
        default: state_q <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_sequencer.sv
// Directed bench for fft_sequencer: one instance with SETTLE_CYCLES=4 and one
// with SETTLE_CYCLES=1, both fed constant mainCalc stub results.
module tb_fft_sequencer;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  localparam logic [63:0] FO1 = 64'h41D0000000000000;
  localparam logic [63:0] FO2 = 64'h41D0000000000001;
  localparam logic [63:0] FO3 = 64'h41D0000000000002;
  localparam logic [63:0] FO4 = 64'h41D0000000000003;

  logic [63:0] fo [4];
  logic [63:0] fo1, fo2, fo3, fo4;

  // instance with SETTLE_CYCLES = 4
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [255:0] fft_frame;
  logic [63:0]  out_data;
  logic [1:0]   out_index;

  // instance with SETTLE_CYCLES = 1
  logic [31:0]  in_data_b = '0;
  logic         in_valid_b = 1'b0;
  logic         out_ready_b = 1'b0;
  logic         in_ready_b, out_valid_b, busy_b;
  logic [255:0] fft_frame_b;
  logic [63:0]  out_data_b;
  logic [1:0]   out_index_b;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] smp [8];

  fft_sequencer #(.SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fft_frame(fft_frame), .fft_out1(fo1), .fft_out2(fo2), .fft_out3(fo3), .fft_out4(fo4),
    .out_data(out_data), .out_index(out_index), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  fft_sequencer #(.SETTLE_CYCLES(1)) u_dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .fft_frame(fft_frame_b), .fft_out1(fo1), .fft_out2(fo2), .fft_out3(fo3), .fft_out4(fo4),
    .out_data(out_data_b), .out_index(out_index_b), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .busy(busy_b)
  );

  assign fo1 = fo[0];
  assign fo2 = fo[1];
  assign fo3 = fo[2];
  assign fo4 = fo[3];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] pack8();
    logic [255:0] f;
    f = '0;
    for (int k = 0; k < 8; k++) f = {f[223:0], smp[k]};
    return f;
  endfunction

  task automatic load_frame();
    in_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = smp[k];
      tick();
    end
    in_valid = 1'b0;
    in_data  = 32'hDEADBEEF;
  endtask

  task automatic wait_out_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL reset_flags: got %b want 100", {in_ready, out_valid, busy});
    end
    n_total++;
    if (fft_frame !== 256'h0) begin
      n_bad++; $display("FAIL reset_frame: got %h want 0", fft_frame);
    end
    n_total++;
    if (out_data !== 64'h0 || out_index !== 2'd0) begin
      n_bad++; $display("FAIL reset_out: got %h/%0d want 0/0", out_data, out_index);
    end
  endtask

  task automatic test_packing_and_order();
    int lat;
    smp = '{32'h40400000, 32'hBF800000, 32'h40800000, 32'h40C00000,
            32'h40000000, 32'h40E00000, 32'h41000000, 32'hC0400000};
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data = smp[k];
      n_total++;
      if (in_ready !== 1'b1) begin
        n_bad++; $display("FAIL pack_in_ready[%0d]: got %b want 1", k, in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      n_bad++; $display("FAIL pack_settle_flags: got in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    n_total++;
    if (fft_frame !== 256'h40400000BF8000004080000040C000004000000040E0000041000000C0400000) begin
      n_bad++; $display("FAIL pack_frame: got %h", fft_frame);
    end
    wait_out_valid(lat);
    n_total++;
    if (lat != 5) begin
      n_bad++; $display("FAIL latency_s4: got %0d want 5", lat);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_index !== 2'(i) || out_data !== fo[i]) begin
        n_bad++;
        $display("FAIL order[%0d]: got v=%b idx=%0d data=%h want 1 %0d %h",
                 i, out_valid, out_index, out_data, i, fo[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      n_bad++; $display("FAIL after_drain_flags: got %b want 100", {in_ready, out_valid, busy});
    end
    n_total++;
    if (fft_frame !== 256'h40400000BF8000004080000040C000004000000040E0000041000000C0400000) begin
      n_bad++; $display("FAIL frame_held: got %h", fft_frame);
    end
  endtask

  task automatic test_stall();
    int lat;
    smp = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
    load_frame();
    wait_out_valid(lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    for (int c = 0; c < 10; c++) begin
      n_total++;
      if (out_valid !== 1'b1 || out_index !== 2'd1 || out_data !== FO2 || in_ready !== 1'b0) begin
        n_bad++;
        $display("FAIL stall[%0d]: got v=%b idx=%0d data=%h rdy=%b want 1 1 %h 0",
                 c, out_valid, out_index, out_data, in_ready, FO2);
      end
      tick();
    end
    in_valid = 1'b0;
    n_total++;
    if (fft_frame !== pack8()) begin
      n_bad++; $display("FAIL stall_frame: got %h want %h", fft_frame, pack8());
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      n_total++;
      if (out_index !== 2'(i) || out_data !== fo[i]) begin
        n_bad++; $display("FAIL stall_resume[%0d]: got %0d %h want %0d %h", i, out_index, out_data, i, fo[i]);
      end
      tick();
    end
    out_ready = 1'b0;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL stall_back_to_load: got %b want 1", in_ready);
    end
  endtask

  task automatic test_input_gaps();
    int k;
    int cyc;
    int lat;
    logic v;
    // NaN payload, -0, +0, smallest denormal, +inf must pass bit-exact
    smp = '{32'h7FC00001, 32'h80000000, 32'h00000001, 32'h00000000,
            32'h7F800000, 32'h807FFFFF, 32'hFFFFFFFF, 32'h3EAAAAAB};
    k = 0;
    cyc = 0;
    while (k < 8 && cyc < 200) begin
      v = 1'($urandom_range(0, 1));
      in_valid = v;
      in_data  = v ? smp[k] : (32'hDEAD0000 | 32'(cyc));
      if (v && in_ready) k++;
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    n_total++;
    if (k != 8) begin
      n_bad++; $display("FAIL gaps_timeout: got %0d accepts want 8", k);
    end
    n_total++;
    if (in_ready !== 1'b0) begin
      n_bad++; $display("FAIL gaps_stop_after_8: got in_ready=%b want 0", in_ready);
    end
    n_total++;
    if (fft_frame !== pack8()) begin
      n_bad++; $display("FAIL gaps_frame: got %h want %h", fft_frame, pack8());
    end
    wait_out_valid(lat);
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    n_total++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL gaps_drained: got %b want 1", in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    smp = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
            32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_data = smp[k];
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (fft_frame !== 256'h0 || {in_ready, out_valid, busy} !== 3'b100 || out_data !== 64'h0) begin
      n_bad++;
      $display("FAIL rst_mid_load: got frame=%h flags=%b data=%h want 0 100 0",
               fft_frame, {in_ready, out_valid, busy}, out_data);
    end
    #2 rst = 1'b0;
    tick();
    smp = '{32'hA0000001, 32'hA0000002, 32'hA0000003, 32'hA0000004,
            32'hA0000005, 32'hA0000006, 32'hA0000007, 32'hA0000008};
    load_frame();
    n_total++;
    if (fft_frame !== pack8() || in_ready !== 1'b0) begin
      n_bad++; $display("FAIL rst_clean_frame: got %h rdy=%b want %h 0", fft_frame, in_ready, pack8());
    end
    wait_out_valid(lat);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({in_ready, out_valid, busy} !== 3'b100 || out_index !== 2'd0 || out_data !== 64'h0 ||
        fft_frame !== 256'h0) begin
      n_bad++;
      $display("FAIL rst_mid_drain: got flags=%b idx=%0d data=%h frame=%h want 100 0 0 0",
               {in_ready, out_valid, busy}, out_index, out_data, fft_frame);
    end
    #2 rst = 1'b0;
    tick();
    smp = '{32'hB0000001, 32'hB0000002, 32'hB0000003, 32'hB0000004,
            32'hB0000005, 32'hB0000006, 32'hB0000007, 32'hB0000008};
    load_frame();
    wait_out_valid(lat);
    n_total++;
    if (lat != 5 || out_index !== 2'd0 || out_data !== FO1 || fft_frame !== pack8()) begin
      n_bad++;
      $display("FAIL rst_recover: got lat=%0d idx=%0d data=%h frame=%h want 5 0 %h %h",
               lat, out_index, out_data, fft_frame, FO1, pack8());
    end
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_boundary();
    int lat;
    int acc;
    int nst;
    int starts [3];
    in_valid_b = 1'b1;
    for (int k = 0; k < 8; k++) begin
      in_data_b = 32'h40000000 + 32'(k);
      tick();
    end
    in_valid_b = 1'b0;
    lat = 1;
    while (out_valid_b !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_total++;
    if (lat != 2) begin
      n_bad++; $display("FAIL latency_s1: got %0d want 2", lat);
    end
    out_ready_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (out_index_b !== 2'(i) || out_data_b !== fo[i]) begin
        n_bad++; $display("FAIL s1_order[%0d]: got %0d %h want %0d %h", i, out_index_b, out_data_b, i, fo[i]);
      end
      tick();
    end
    in_valid_b = 1'b1;
    acc = 0;
    nst = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      in_data_b = 32'h3F800000 + 32'(cyc);
      if (in_ready_b === 1'b1) begin
        if (acc % 8 == 0 && nst < 3) begin
          starts[nst] = cyc;
          nst++;
        end
        acc++;
      end
      tick();
    end
    in_valid_b  = 1'b0;
    out_ready_b = 1'b0;
    n_total++;
    if (nst != 3) begin
      n_bad++; $display("FAIL b2b_frames: got %0d frame starts want 3", nst);
    end else begin
      n_total++;
      if (starts[1] - starts[0] != 13 || starts[2] - starts[1] != 13) begin
        n_bad++;
        $display("FAIL b2b_period: got %0d,%0d want 13,13", starts[1] - starts[0], starts[2] - starts[1]);
      end
    end
  endtask

  initial begin
    fo[0] = FO1;
    fo[1] = FO2;
    fo[2] = FO3;
    fo[3] = FO4;
    test_reset();
    test_packing_and_order();
    test_stall();
    test_input_gaps();
    test_reset_mid();
    test_boundary();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
